// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 data-memory sequencer: access-stage encodings and FSM states.
package lc3_mem_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    READ_IND = 2'd1,
    WRITE    = 2'd2,
    IDLE     = 2'd3
  } mem_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_RD,
    S_D_PTR,
    S_D_RD,
    S_D_WR,
    S_RESP
  } seq_state_t;

endpackage

// File: rtl/lc3_phase_timer.sv
// 4-bit loadable down-counter timing one memory phase; done is high while the count is zero.
module lc3_phase_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/lc3_mem_sequencer.sv
// Arbitrates fetch and load/store requesters onto the single LC-3 memory access stage,
// sequencing direct accesses as one phase and LDI/STI as pointer phase plus data phase.
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [WORD_W-1:0] f_addr,
  output logic              f_ack,
  output logic [WORD_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic              d_indirect,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic [1:0]        mem_state,
  output logic              m_control,
  output logic [WORD_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_data,
  input  logic [WORD_W-1:0] memout,
  output logic              busy
);

  localparam logic [3:0] RELOAD = 4'(ACCESS_CYCLES - 1);

  seq_state_t        state, next_state;
  mem_state_t        ms;
  logic [WORD_W-1:0] f_addr_q, d_addr_q, wdata_q, ptr_q;
  logic              write_q, indirect_q;
  logic              sel_fetch_q;
  logic              last_data_q;   // 1 = data was granted last, 0 = fetch
  logic              timer_load, phase_done;
  logic              grant_d, grant_f;

  lc3_phase_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (RELOAD),
    .done     (phase_done)
  );

  // On a tie, the requester that was not served last wins.
  assign grant_d = d_req && (!f_req || !last_data_q);
  assign grant_f = f_req && !grant_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_d) begin
          timer_load = 1'b1;
          if (d_indirect)   next_state = S_D_PTR;
          else if (d_write) next_state = S_D_WR;
          else              next_state = S_D_RD;
        end else if (grant_f) begin
          timer_load = 1'b1;
          next_state = S_F_RD;
        end
      end
      S_F_RD, S_D_RD, S_D_WR: begin
        if (phase_done) next_state = S_RESP;
      end
      S_D_PTR: begin
        if (phase_done) begin
          timer_load = 1'b1;
          next_state = write_q ? S_D_WR : S_D_RD;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_addr_q    <= '0;
      d_addr_q    <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      write_q     <= 1'b0;
      indirect_q  <= 1'b0;
      sel_fetch_q <= 1'b0;
      last_data_q <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (grant_d) begin
          d_addr_q    <= d_addr;
          wdata_q     <= d_wdata;
          write_q     <= d_write;
          indirect_q  <= d_indirect;
          sel_fetch_q <= 1'b0;
          last_data_q <= 1'b1;
        end else if (grant_f) begin
          f_addr_q    <= f_addr;
          sel_fetch_q <= 1'b1;
          last_data_q <= 1'b0;
        end
      end
      // memout is only trusted on the final cycle of a phase.
      if (phase_done) begin
        if (state == S_D_PTR) ptr_q   <= memout;
        if (state == S_F_RD)  f_rdata <= memout;
        if (state == S_D_RD)  d_rdata <= memout;
      end
    end
  end

  always_comb begin
    ms        = IDLE;
    m_addr    = '0;
    m_data    = '0;
    m_control = 1'b0;
    case (state)
      S_F_RD: begin
        ms     = READ;
        m_addr = f_addr_q;
      end
      S_D_PTR: begin
        ms     = READ_IND;
        m_addr = d_addr_q;
      end
      S_D_RD: begin
        ms        = READ;
        m_control = indirect_q;
        m_addr    = indirect_q ? ptr_q : d_addr_q;
      end
      S_D_WR: begin
        ms        = WRITE;
        m_control = indirect_q;
        m_addr    = indirect_q ? ptr_q : d_addr_q;
        m_data    = wdata_q;
      end
      default: ms = IDLE;
    endcase
  end

  assign mem_state = ms;
  assign f_ack     = (state == S_RESP) && sel_fetch_q;
  assign d_ack     = (state == S_RESP) && !sel_fetch_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Directed bench: a = instance with one-cycle phases, b = instance with two-cycle phases.
module tb_lc3_mem_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic a_f_req, a_f_ack, a_d_req, a_d_write, a_d_indirect, a_d_ack, a_m_control, a_busy;
  logic [15:0] a_f_addr, a_f_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_m_addr, a_m_data, a_memout;
  logic [1:0] a_mem_state;
  logic b_f_req, b_f_ack, b_d_req, b_d_write, b_d_indirect, b_d_ack, b_m_control, b_busy;
  logic [15:0] b_f_addr, b_f_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_data, b_memout;
  logic [1:0] b_mem_state;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h3000: mem_rd = 16'h1234;
      16'h3001: mem_rd = 16'hC0DE;
      16'h4000: mem_rd = 16'h5000;
      16'h4010: mem_rd = 16'h1111;
      16'h4020: mem_rd = 16'h6000;
      16'h5000: mem_rd = 16'hBEEF;
      16'h6000: mem_rd = 16'h7777;
      default:  mem_rd = 16'hDEAD;
    endcase
  endfunction

  assign a_memout = mem_rd(a_m_addr);
  assign b_memout = mem_rd(b_m_addr);

  lc3_mem_sequencer #(.ACCESS_CYCLES(1)) dut_a (
    .clock(clock), .reset(reset),
    .f_req(a_f_req), .f_addr(a_f_addr), .f_ack(a_f_ack), .f_rdata(a_f_rdata),
    .d_req(a_d_req), .d_write(a_d_write), .d_indirect(a_d_indirect), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_state(a_mem_state), .m_control(a_m_control), .m_addr(a_m_addr), .m_data(a_m_data),
    .memout(a_memout), .busy(a_busy)
  );

  lc3_mem_sequencer #(.ACCESS_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_ack(b_f_ack), .f_rdata(b_f_rdata),
    .d_req(b_d_req), .d_write(b_d_write), .d_indirect(b_d_indirect), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_state(b_mem_state), .m_control(b_m_control), .m_addr(b_m_addr), .m_data(b_m_data),
    .memout(b_memout), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  exp_ms;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] got[4];
    logic [1:0] want[4];
    int n;

    vt[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 2'd0, 16'h1234};
    vt[1] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 2'd0, 16'h5000};
    vt[2] = '{1'b1, 1'b1, 16'h4010, 16'hA5A5, 2'd2, 16'h5000};
    vt[3] = '{1'b0, 1'b0, 16'h3001, 16'h0000, 2'd0, 16'hC0DE};
    vt[4] = '{1'b1, 1'b0, 16'h5000, 16'h0000, 2'd0, 16'hBEEF};
    vt[5] = '{1'b1, 1'b1, 16'h4020, 16'h0F0F, 2'd2, 16'hBEEF};

    {a_f_req, a_d_req, a_d_write, a_d_indirect} = '0;
    {a_f_addr, a_d_addr, a_d_wdata} = '0;
    {b_f_req, b_d_req, b_d_write, b_d_indirect} = '0;
    {b_f_addr, b_d_addr, b_d_wdata} = '0;

    // Reset state and a quiet idle period.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_m_control", b_m_control, 0);
    chk("rst_m_addr", b_m_addr, 0);
    chk("rst_m_data", b_m_data, 0);
    chk("rst_f_rdata", b_f_rdata, 0);
    chk("rst_d_rdata", b_d_rdata, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_mem_state", b_mem_state, 3);
      chk("idle_busy", b_busy, 0);
      chk("idle_acks", {b_f_ack, b_d_ack, a_f_ack, a_d_ack}, 0);
      chk("idle_a_mem_state", a_mem_state, 3);
    end

    // Direct accesses on the one-cycle instance: phase at cycle 1, ack at cycle 2.
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      a_f_req   = !vt[v].is_data;
      a_d_req   = vt[v].is_data;
      a_d_write = vt[v].wr;
      a_f_addr  = vt[v].addr;
      a_d_addr  = vt[v].addr;
      a_d_wdata = vt[v].wdata;
      @(negedge clock);
      a_f_addr = 16'hFFFF;
      a_d_addr = 16'hFFFF;
      chk($sformatf("v%0d_mem_state", v), a_mem_state, vt[v].exp_ms);
      chk($sformatf("v%0d_m_addr", v), a_m_addr, vt[v].addr);
      chk($sformatf("v%0d_m_data", v), a_m_data, vt[v].wr ? vt[v].wdata : 16'h0);
      chk($sformatf("v%0d_m_control", v), a_m_control, 0);
      chk($sformatf("v%0d_busy", v), a_busy, 1);
      @(negedge clock);
      chk($sformatf("v%0d_f_ack", v), a_f_ack, !vt[v].is_data);
      chk($sformatf("v%0d_d_ack", v), a_d_ack, vt[v].is_data);
      chk($sformatf("v%0d_resp_mem_state", v), a_mem_state, 3);
      if (vt[v].is_data) chk($sformatf("v%0d_d_rdata", v), a_d_rdata, vt[v].exp_rdata);
      else               chk($sformatf("v%0d_f_rdata", v), a_f_rdata, vt[v].exp_rdata);
      a_f_req = 1'b0;
      a_d_req = 1'b0;
      @(negedge clock);
      chk($sformatf("v%0d_idle_busy", v), a_busy, 0);
    end

    // LDI with two-cycle phases: ack at cycle 5.
    @(negedge clock);
    b_d_req = 1'b1; b_d_indirect = 1'b1; b_d_write = 1'b0; b_d_addr = 16'h4000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c <= 2) begin
        chk("ldi_ptr_mem_state", b_mem_state, 1);
        chk("ldi_ptr_m_addr", b_m_addr, 16'h4000);
        chk("ldi_ptr_m_control", b_m_control, 0);
      end else if (c <= 4) begin
        chk("ldi_rd_mem_state", b_mem_state, 0);
        chk("ldi_rd_m_addr", b_m_addr, 16'h5000);
        chk("ldi_rd_m_control", b_m_control, 1);
      end
      chk("ldi_d_ack", b_d_ack, c == 5);
    end
    chk("ldi_d_rdata", b_d_rdata, 16'hBEEF);
    chk("ldi_f_ack", b_f_ack, 0);
    b_d_req = 1'b0;
    @(negedge clock);
    chk("ldi_done_busy", b_busy, 0);

    // STR: store leaves d_rdata untouched.
    b_d_req = 1'b1; b_d_indirect = 1'b0; b_d_write = 1'b1;
    b_d_addr = 16'h4010; b_d_wdata = 16'hA5A5;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c <= 2) begin
        chk("str_mem_state", b_mem_state, 2);
        chk("str_m_data", b_m_data, 16'hA5A5);
        chk("str_m_control", b_m_control, 0);
        chk("str_m_addr", b_m_addr, 16'h4010);
      end
      chk("str_d_ack", b_d_ack, c == 3);
    end
    chk("str_d_rdata", b_d_rdata, 16'hBEEF);
    b_d_req = 1'b0;
    @(negedge clock);

    // STI aborted by reset during the pointer phase.
    b_d_req = 1'b1; b_d_indirect = 1'b1; b_d_write = 1'b1;
    b_d_addr = 16'h4020; b_d_wdata = 16'h1357;
    @(negedge clock);
    chk("abort_ptr_mem_state", b_mem_state, 1);
    reset = 1'b1;
    b_d_req = 1'b0;
    #1;
    chk("abort_mem_state", b_mem_state, 3);
    chk("abort_busy", b_busy, 0);
    chk("abort_d_ack", b_d_ack, 0);
    @(negedge clock);
    chk("abort_hold_d_ack", b_d_ack, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_no_resume", b_mem_state, 3);

    // Fresh STI completes normally.
    b_d_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c <= 2) begin
        chk("sti_ptr_mem_state", b_mem_state, 1);
        chk("sti_ptr_m_addr", b_m_addr, 16'h4020);
      end else if (c <= 4) begin
        chk("sti_wr_mem_state", b_mem_state, 2);
        chk("sti_wr_m_addr", b_m_addr, 16'h6000);
        chk("sti_wr_m_control", b_m_control, 1);
        chk("sti_wr_m_data", b_m_data, 16'h1357);
      end
      chk("sti_d_ack", b_d_ack, c == 5);
    end
    chk("sti_d_rdata", b_d_rdata, 16'h0000);
    b_d_req = 1'b0;
    @(negedge clock);

    // Both requests held after reset: data wins the first tie, then alternate.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    b_f_req = 1'b1; b_f_addr = 16'h3000;
    b_d_req = 1'b1; b_d_indirect = 1'b0; b_d_write = 1'b0; b_d_addr = 16'h4000;
    want[0] = 2'd1; want[1] = 2'd0; want[2] = 2'd1; want[3] = 2'd0;
    for (int k = 0; k < 4; k++) got[k] = 2'd2;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clock);
      if (b_f_ack || b_d_ack) begin
        chk("arb_ack_onehot", {15'd0, b_f_ack & b_d_ack}, 0);
        got[n] = b_d_ack ? 2'd1 : 2'd0;
        if (b_d_ack) chk("arb_d_rdata", b_d_rdata, 16'h5000);
        else         chk("arb_f_rdata", b_f_rdata, 16'h1234);
        n++;
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("arb_grant%0d", k), {14'd0, got[k]}, {14'd0, want[k]});
    b_f_req = 1'b0;
    b_d_req = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
